// File: rtl/fetch_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_buffer
//
// Instruction fetch front-end that sits directly upstream of decode. It fetches
// 32-bit words sequentially from instruction memory over a req/ack handshake,
// buffers each word together with its PC in a DEPTH-entry FIFO, and presents
// the FIFO head to decode. A redirect flushes the buffer and restarts fetch at
// a new (word-aligned) PC.
//
// Handshakes:
//   memory side : memReq/memAddr are held stable from issue until the cycle
//                 memAck=1; that cycle completes the request and memData is
//                 captured. A request is never withdrawn except by reset.
//   decode side : a transfer happens on every clock edge where
//                 instrValid && instrReady. instrValid, instruction and instrPC
//                 come from registers only; instrReady has no comb path to them.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   PC_WIDTH  width of fetch/branch addresses
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clock        in   processor clock, all state on posedge
//   resetN       in   asynchronous, active-low reset
//   memReq       out  fetch request to instruction memory
//   memAddr      out  word address of the outstanding request
//   memAck       in   memory completes the request this cycle
//   memData      in   instruction word, valid with memAck
//   instrValid   out  head entry available to decode
//   instruction  out  head instruction word
//   instrPC      out  PC of head instruction
//   instrReady   in   decode consumes head when instrValid && instrReady
//   redirect     in   branch taken: flush and refetch
//   redirectPC   in   new fetch PC (bits [1:0] ignored)
//   bufferCount  out  number of occupied FIFO entries
//   fetchState   out  current fetch FSM state (0=IDLE, 1=WAIT, 2=DISCARD)
//   stallCycles  out  (FETCH_PERF_COUNTERS_EN only) cycles decode was starved
//   flushCount   out  (FETCH_PERF_COUNTERS_EN only) number of redirect cycles
//
// Optional feature: define FETCH_PERF_COUNTERS_EN to build the saturating
// performance counters and their ports.
// ---------------------------------------------------------------------------
module fetch_prefetch_buffer #(
   parameter int                    DEPTH    = 4,
   parameter int                    PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
   input  logic                          clock,
   input  logic                          resetN,
   output logic                          memReq,
   output logic [PC_WIDTH-1:0]           memAddr,
   input  logic                          memAck,
   input  logic [31:0]                   memData,
   output logic                          instrValid,
   output logic [31:0]                   instruction,
   output logic [PC_WIDTH-1:0]           instrPC,
   input  logic                          instrReady,
   input  logic                          redirect,
   input  logic [PC_WIDTH-1:0]           redirectPC,
   output logic [$clog2(DEPTH+1)-1:0]    bufferCount,
   output logic [1:0]                    fetchState
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0]                   stallCycles,
   output logic [15:0]                   flushCount
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t                state;
   logic [PC_WIDTH-1:0]   fetch_pc;
   logic [PC_WIDTH-1:0]   fifo_pc   [DEPTH];
   logic [31:0]           fifo_word [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   logic                  pop;
   logic                  push;
   logic [CW:0]           count_after_pop;
   logic [CW:0]           count_next;
   logic                  space_idle;
   logic                  space_wait;
   logic [PC_WIDTH-1:0]   aligned_redirect;
   logic [PC_WIDTH-1:0]   next_pc;

   assign fetchState  = 2'(state);

   // Head of the FIFO is read straight out of the storage registers.
   assign instrValid  = (bufferCount != '0);
   assign instruction = fifo_word[rd_ptr];
   assign instrPC     = fifo_pc[rd_ptr];

   assign pop  = instrValid && instrReady;
   // A word returned while a redirect is active belongs to the old path.
   assign push = (state == WAIT) && memAck && !redirect;

   assign count_after_pop = {1'b0, bufferCount} - {{CW{1'b0}}, pop};
   assign count_next      = count_after_pop + {{CW{1'b0}}, push};

   // A new request reserves a slot at issue time. From IDLE nothing is in
   // flight; on an ack in WAIT the word being pushed now occupies its slot,
   // so the next request needs one more free entry.
   assign space_idle = (count_after_pop < DEPTH_W);
   assign space_wait = ((count_after_pop + (CW + 1)'(1)) < DEPTH_W);

   assign aligned_redirect = redirectPC & ~PC_WIDTH'(3);
   assign next_pc          = fetch_pc + PC_WIDTH'(4);

   // -------------------------------------------------------------------------
   // FIFO storage and occupancy
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc[i]   <= '0;
            fifo_word[i] <= '0;
         end
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         bufferCount <= '0;
      end else if (redirect) begin
         // Flush wins over any simultaneous push or pop.
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         bufferCount <= '0;
      end else begin
         if (push) begin
            fifo_pc[wr_ptr]   <= fetch_pc;
            fifo_word[wr_ptr] <= memData;
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         bufferCount <= count_next[CW-1:0];
      end
   end

   // -------------------------------------------------------------------------
   // Fetch FSM. fetch_pc is the address of the outstanding request while in
   // WAIT, and the next address to fetch otherwise.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         memReq   <= 1'b0;
         memAddr  <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               if (redirect) begin
                  // Buffer is being flushed, so a slot is free: issue the
                  // redirect target straight away.
                  fetch_pc <= aligned_redirect;
                  memAddr  <= aligned_redirect;
                  memReq   <= 1'b1;
                  state    <= WAIT;
               end else if (space_idle) begin
                  memAddr  <= fetch_pc;
                  memReq   <= 1'b1;
                  state    <= WAIT;
               end
            end

            WAIT: begin
               if (memAck) begin
                  if (redirect) begin
                     // Old word is dropped; the completed request frees the
                     // bus, so the redirect target goes out next cycle.
                     fetch_pc <= aligned_redirect;
                     memAddr  <= aligned_redirect;
                     memReq   <= 1'b1;
                     state    <= WAIT;
                  end else begin
                     fetch_pc <= next_pc;
                     if (space_wait) begin
                        memAddr <= next_pc;
                        memReq  <= 1'b1;
                        state   <= WAIT;
                     end else begin
                        memReq  <= 1'b0;
                        state   <= IDLE;
                     end
                  end
               end else if (redirect) begin
                  // The request cannot be withdrawn; keep it on the bus and
                  // throw away whatever comes back.
                  fetch_pc <= aligned_redirect;
                  state    <= DISCARD;
               end
            end

            DISCARD: begin
               if (redirect) begin
                  fetch_pc <= aligned_redirect;
               end
               if (memAck) begin
                  memReq <= 1'b0;
                  state  <= IDLE;
               end
            end

            default: begin
               memReq <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Performance counters (saturating)
   // -------------------------------------------------------------------------
`ifdef FETCH_PERF_COUNTERS_EN
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         stallCycles <= '0;
         flushCount  <= '0;
      end else begin
         if (instrReady && !instrValid && (stallCycles != '1)) begin
            stallCycles <= stallCycles + 32'd1;
         end
         if (redirect && (flushCount != '1)) begin
            flushCount <= flushCount + 16'd1;
         end
      end
   end
`else
   // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_buffer
//
// Directed bench for fetch_prefetch_buffer. Main instance uses RESET_PC=0;
// a second instance with RESET_PC=32'hFFFFFFF8 exercises address wrap-around.
// Inputs are driven 1 time unit after each rising edge, outputs are sampled at
// the same point, so every value checked is a settled register output.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_buffer;

   // ---------------- clock / reset ----------------
   logic clock;
   logic resetN;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- main DUT signals ----------------
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck;
   logic [31:0] memData;
   logic        instrValid;
   logic [31:0] instruction;
   logic [31:0] instrPC;
   logic        instrReady;
   logic        redirect;
   logic [31:0] redirectPC;
   logic [2:0]  bufferCount;
   logic [1:0]  fetchState;

   // ---------------- wrap DUT signals ----------------
   logic        w_memReq;
   logic [31:0] w_memAddr;
   logic        w_memAck;
   logic [31:0] w_memData;
   logic        w_instrValid;
   logic [31:0] w_instruction;
   logic [31:0] w_instrPC;
   logic [2:0]  w_bufferCount;
   logic [1:0]  w_fetchState;

`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] stallCycles;
   logic [15:0] flushCount;
   logic [31:0] w_stallCycles;
   logic [15:0] w_flushCount;
`endif

   fetch_prefetch_buffer #(
      .DEPTH    (4),
      .PC_WIDTH (32),
      .RESET_PC (32'h0000_0000)
   ) u_dut (
      .clock       (clock),
      .resetN      (resetN),
      .memReq      (memReq),
      .memAddr     (memAddr),
      .memAck      (memAck),
      .memData     (memData),
      .instrValid  (instrValid),
      .instruction (instruction),
      .instrPC     (instrPC),
      .instrReady  (instrReady),
      .redirect    (redirect),
      .redirectPC  (redirectPC),
      .bufferCount (bufferCount),
      .fetchState  (fetchState)
`ifdef FETCH_PERF_COUNTERS_EN
      ,
      .stallCycles (stallCycles),
      .flushCount  (flushCount)
`endif
   );

   fetch_prefetch_buffer #(
      .DEPTH    (4),
      .PC_WIDTH (32),
      .RESET_PC (32'hFFFF_FFF8)
   ) u_wrap (
      .clock       (clock),
      .resetN      (resetN),
      .memReq      (w_memReq),
      .memAddr     (w_memAddr),
      .memAck      (w_memAck),
      .memData     (w_memData),
      .instrValid  (w_instrValid),
      .instruction (w_instruction),
      .instrPC     (w_instrPC),
      .instrReady  (1'b1),
      .redirect    (1'b0),
      .redirectPC  (32'h0000_0000),
      .bufferCount (w_bufferCount),
      .fetchState  (w_fetchState)
`ifdef FETCH_PERF_COUNTERS_EN
      ,
      .stallCycles (w_stallCycles),
      .flushCount  (w_flushCount)
`endif
   );

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];
   logic [31:0] wrap_q[$];
   int          total_checks;
   int          passed_checks;
   int          failed_checks;
   bit          auto_mem;
   int          ack_count;

   function automatic logic [31:0] data_of(input logic [31:0] addr);
      return addr ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_checks++;
      assert (obs === exp) passed_checks++;
      else begin
         failed_checks++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // One clock: wait for the edge, settle, then let the memory models respond.
   task automatic tick();
      @(posedge clock);
      #1;
      if (auto_mem) begin
         memAck = 1'b0;
         if (memReq) begin
            memAck  = 1'b1;
            memData = data_of(memAddr);
            ack_count++;
         end
      end
      w_memAck  = w_memReq;
      w_memData = data_of(w_memAddr);
      if (w_memReq && (wrap_q.size() < 8)) wrap_q.push_back(w_memAddr);
   endtask

   task automatic apply_reset();
      resetN     = 1'b0;
      memAck     = 1'b0;
      memData    = '0;
      instrReady = 1'b0;
      redirect   = 1'b0;
      redirectPC = '0;
      auto_mem   = 1'b0;
      ack_count  = 0;
      tick();
      tick();
      resetN = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] pc;
      total_checks  = 0;
      passed_checks = 0;
      failed_checks = 0;
      w_memAck      = 1'b0;
      w_memData     = '0;

      // Reset state
      apply_reset();
      resetN = 1'b0;
      #1;
      check("rst_memReq",      32'(memReq),      32'd0);
      check("rst_memAddr",     memAddr,          32'h0);
      check("rst_instrValid",  32'(instrValid),  32'd0);
      check("rst_bufferCount", 32'(bufferCount), 32'd0);
      check("rst_instruction", instruction,      32'h0);
      check("rst_instrPC",     instrPC,          32'h0);
      check("rst_state",       32'(fetchState),  32'd0);
      check("rst_w_memAddr",   w_memAddr,        32'hFFFF_FFF8);
      tick();
      resetN = 1'b1;

      // 1: streaming fetch, memory acks immediately, decode always ready
      auto_mem   = 1'b1;
      instrReady = 1'b1;
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
      tick();
      check("t1_first_req",  32'(memReq), 32'd1);
      check("t1_first_addr", memAddr,     32'h0);
      for (int i = 0; i < 5; i++) begin
         pc = exp_q.pop_front();
         tick();
         check("t1_valid",    32'(instrValid), 32'd1);
         check("t1_instrPC",  instrPC,         pc);
         check("t1_instr",    instruction,     data_of(pc));
         check("t1_next_addr", memAddr,        pc + 32'd4);
      end

      // 2: decode stalled, buffer fills to 4, then one pop re-opens fetch
      apply_reset();
      auto_mem = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("t2_count_full", 32'(bufferCount), 32'd4);
      check("t2_req_low",    32'(memReq),      32'd0);
      tick();
      check("t2_req_still_low", 32'(memReq), 32'd0);
      check("t2_ack_count",     32'(ack_count), 32'd4);
      check("t2_head_pc",       instrPC,        32'h0);
      instrReady = 1'b1;
      tick();
      instrReady = 1'b0;
      check("t2_req_after_pop",  32'(memReq),      32'd1);
      check("t2_addr_after_pop", memAddr,          32'h10);
      check("t2_count_after_pop", 32'(bufferCount), 32'd3);
      check("t2_head_after_pop", instrPC,          32'h4);

      // 3: redirect while waiting; late ack must be discarded
      apply_reset();
      tick();
      check("t3_wait_state", 32'(fetchState), 32'd1);
      check("t3_wait_req",   32'(memReq),     32'd1);
      redirect   = 1'b1;
      redirectPC = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      check("t3_discard_state", 32'(fetchState), 32'd2);
      check("t3_req_held",      32'(memReq),     32'd1);
      check("t3_addr_held",     memAddr,         32'h0);
      tick();
      tick();
      check("t3_req_still_held", 32'(memReq), 32'd1);
      memAck  = 1'b1;
      memData = 32'hBAD0_BAD0;
      tick();
      memAck = 1'b0;
      check("t3_dropped_valid", 32'(instrValid),  32'd0);
      check("t3_dropped_count", 32'(bufferCount), 32'd0);
      check("t3_idle_req",      32'(memReq),      32'd0);
      tick();
      check("t3_refetch_req",  32'(memReq), 32'd1);
      check("t3_refetch_addr", memAddr,     32'h100);
      memAck  = 1'b1;
      memData = data_of(32'h100);
      tick();
      memAck = 1'b0;
      check("t3_new_valid", 32'(instrValid), 32'd1);
      check("t3_new_pc",    instrPC,         32'h100);
      check("t3_new_instr", instruction,     data_of(32'h100));

      // 4: redirect coincident with ack and pop
      apply_reset();
      auto_mem   = 1'b1;
      instrReady = 1'b1;
      tick();
      tick();
      check("t4_pre_valid", 32'(instrValid), 32'd1);
      check("t4_pre_ack",   32'(memAck),     32'd1);
      redirect   = 1'b1;
      redirectPC = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      check("t4_count",      32'(bufferCount), 32'd0);
      check("t4_valid",      32'(instrValid),  32'd0);
      check("t4_req",        32'(memReq),      32'd1);
      check("t4_req_addr",   memAddr,          32'h200);
      tick();
      check("t4_new_valid", 32'(instrValid), 32'd1);
      check("t4_new_pc",    instrPC,         32'h200);
      check("t4_new_instr", instruction,     data_of(32'h200));

      // 5: wrap-around from RESET_PC=FFFFFFF8 (captured since first reset)
      exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      check("t5_wrap_len", 32'(wrap_q.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++) begin
         pc = exp_q.pop_front();
         check("t5_wrap_addr", (i < wrap_q.size()) ? wrap_q[i] : 32'hDEAD_DEAD, pc);
      end

`ifdef FETCH_PERF_COUNTERS_EN
      // 6: 5 starved cycles and 2 redirect cycles
      apply_reset();
      tick();
      instrReady = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      instrReady = 1'b0;
      redirect   = 1'b1;
      redirectPC = 32'h0000_0040;
      tick();
      tick();
      redirect = 1'b0;
      tick();
      check("t6_stall", stallCycles,      32'd5);
      check("t6_flush", 32'(flushCount),  32'd2);
      resetN = 1'b0;
      #1;
      check("t6_stall_rst", stallCycles,     32'd0);
      check("t6_flush_rst", 32'(flushCount), 32'd0);
      tick();
      resetN = 1'b1;
`endif

      tick();
      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
